// File: rtl/viterbi_frame_ctrl_if.sv
// Frame-level handshake and enable bundle between the PS frame buffer, the
// Viterbi frame controller and the slice / ACS / traceback stages.
interface viterbi_frame_ctrl_if #(
    parameter int STEPS_W = 7
);
    logic               i_frame_valid;
    logic               o_frame_ready;
    logic               i_code_rate;
    logic               o_code_rate;
    logic               o_en_s;
    logic               i_ood;
    logic               o_en_acs;
    logic               o_en_tb;
    logic [STEPS_W-1:0] o_steps;
    logic               o_busy;
    logic               o_done;
    logic               i_ack;
    logic               i_abort;
    logic               o_err;

    modport master (
        output i_frame_valid, i_code_rate, i_ood, i_ack, i_abort,
        input  o_frame_ready, o_code_rate, o_en_s, o_en_acs, o_en_tb,
               o_steps, o_busy, o_done, o_err
    );

    modport slave (
        input  i_frame_valid, i_code_rate, i_ood, i_ack, i_abort,
        output o_frame_ready, o_code_rate, o_en_s, o_en_acs, o_en_tb,
               o_steps, o_busy, o_done, o_err
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: slicer -> delayed ACS -> traceback -> done/ack.
// Optional slice timeout with ERR state is enabled by defining VITERBI_CTRL_TIMEOUT_EN.
module viterbi_frame_ctrl #(
    parameter int PIPE_DELAY = 2,
    parameter int TB_DEPTH   = 16,
    parameter int MAX_STEPS  = 69
) (
    input  logic                 clk,
    input  logic                 rst_n,
    viterbi_frame_ctrl_if.slave  bus
);
    localparam int STEPS_W = $clog2(MAX_STEPS + 1);
    localparam int TB_W    = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
    localparam logic [STEPS_W-1:0] MAX_CNT = STEPS_W'(MAX_STEPS);
    localparam logic [TB_W-1:0]    TB_LAST = TB_W'(TB_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SLICE,
        DRAIN,
        TRACE,
        DONE
`ifdef VITERBI_CTRL_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t                state_q;
    logic                  frame_ready_q;
    logic                  code_rate_q;
    logic                  en_s_q;
    logic                  en_tb_q;
    logic                  busy_q;
    logic                  done_q;
    logic [PIPE_DELAY-1:0] pipe_q;
    logic [PIPE_DELAY-1:0] pipe_d;
    logic [STEPS_W-1:0]    step_cnt_q;
    logic [STEPS_W-1:0]    step_cnt_d;
    logic [STEPS_W-1:0]    steps_q;
    logic [TB_W-1:0]       tb_cnt_q;
`ifdef VITERBI_CTRL_TIMEOUT_EN
    logic                  err_q;
`endif

    // Enable pipe toward the ACS stage: bit 0 takes the slicer enable.
    assign pipe_d[0] = en_s_q;
    generate
        for (genvar gi = 1; gi < PIPE_DELAY; gi++) begin : g_pipe
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    endgenerate

    // Saturating increment so the step counter can never wrap.
    assign step_cnt_d = (step_cnt_q == MAX_CNT) ? MAX_CNT : step_cnt_q + STEPS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_ready_q <= 1'b0;
            code_rate_q   <= 1'b0;
            en_s_q        <= 1'b0;
            en_tb_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pipe_q        <= '0;
            step_cnt_q    <= '0;
            steps_q       <= '0;
            tb_cnt_q      <= '0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            pipe_q <= pipe_d;
            if (bus.i_abort) begin
                state_q       <= IDLE;
                frame_ready_q <= 1'b1;
                busy_q        <= 1'b0;
                en_s_q        <= 1'b0;
                en_tb_q       <= 1'b0;
                done_q        <= 1'b0;
                pipe_q        <= '0;
                step_cnt_q    <= '0;
                tb_cnt_q      <= '0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
                err_q         <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        frame_ready_q <= 1'b1;
                        if (bus.i_frame_valid && frame_ready_q) begin
                            code_rate_q   <= bus.i_code_rate;
                            step_cnt_q    <= '0;
                            frame_ready_q <= 1'b0;
                            busy_q        <= 1'b1;
                            en_s_q        <= 1'b1;
                            state_q       <= SLICE;
                        end
                    end
                    SLICE: begin
                        step_cnt_q <= step_cnt_d;
                        if (bus.i_ood) begin
                            steps_q <= step_cnt_d;
                            en_s_q  <= 1'b0;
                            state_q <= DRAIN;
                        end
`ifdef VITERBI_CTRL_TIMEOUT_EN
                        else if (step_cnt_d == MAX_CNT) begin
                            steps_q <= MAX_CNT;
                            en_s_q  <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
`endif
                    end
                    DRAIN: begin
                        // Leave once the final ACS-enable cycle is the current one.
                        if (pipe_d == '0) begin
                            en_tb_q  <= 1'b1;
                            tb_cnt_q <= '0;
                            state_q  <= TRACE;
                        end
                    end
                    TRACE: begin
                        if (tb_cnt_q == TB_LAST) begin
                            en_tb_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            tb_cnt_q <= tb_cnt_q + TB_W'(1);
                        end
                    end
                    DONE: begin
                        if (bus.i_ack) begin
                            done_q        <= 1'b0;
                            busy_q        <= 1'b0;
                            frame_ready_q <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
`ifdef VITERBI_CTRL_TIMEOUT_EN
                    ERR: begin
                        if (bus.i_ack) begin
                            err_q         <= 1'b0;
                            busy_q        <= 1'b0;
                            frame_ready_q <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_frame_ready = frame_ready_q;
    assign bus.o_code_rate   = code_rate_q;
    assign bus.o_en_s        = en_s_q;
    assign bus.o_en_acs      = pipe_q[PIPE_DELAY-1];
    assign bus.o_en_tb       = en_tb_q;
    assign bus.o_steps       = steps_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
`ifdef VITERBI_CTRL_TIMEOUT_EN
    assign bus.o_err         = err_q;
`else
    assign bus.o_err         = 1'b0;
`endif
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl (PIPE_DELAY=2, TB_DEPTH=16, MAX_STEPS=69).
module tb_viterbi_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    int cyc = 0, cnt_s = 0, cnt_acs = 0, cnt_tb = 0, cnt_done = 0;
    int rise_s = 0, rise_acs = 0, accepts = 0, overlap = 0;
    logic prev_s = 1'b0, prev_acs = 1'b0, prev_busy = 1'b0;

    viterbi_frame_ctrl_if #(.STEPS_W(7)) bus ();

    viterbi_frame_ctrl #(
        .PIPE_DELAY(2),
        .TB_DEPTH  (16),
        .MAX_STEPS (69)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Activity counters sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (bus.o_en_s)   cnt_s++;
        if (bus.o_en_acs) cnt_acs++;
        if (bus.o_en_tb)  cnt_tb++;
        if (bus.o_done)   cnt_done++;
        if (bus.o_en_tb && bus.o_en_acs) overlap++;
        if (bus.o_en_s && !prev_s)       rise_s = cyc;
        if (bus.o_en_acs && !prev_acs)   rise_acs = cyc;
        if (bus.o_busy && !prev_busy)    accepts++;
        prev_s    = bus.o_en_s;
        prev_acs  = bus.o_en_acs;
        prev_busy = bus.o_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int g = 0;
        while (bus.o_done !== 1'b1 && g < 300) begin
            tick();
            g++;
        end
        check("done_reached", {31'd0, bus.o_done}, 32'd1);
    endtask

    // Handshake a frame, assert i_ood in slice cycle n_ood, optionally flip i_code_rate.
    task automatic run_frame(input logic rate, input int n_ood, input int toggle_at, input logic keep_valid);
        bus.i_frame_valid = 1'b1;
        bus.i_code_rate   = rate;
        tick();
        if (!keep_valid) bus.i_frame_valid = 1'b0;
        for (int k = 1; k <= n_ood; k++) begin
            if (k == toggle_at) bus.i_code_rate = ~rate;
            if (k == n_ood) bus.i_ood = 1'b1;
            tick();
            bus.i_ood = 1'b0;
        end
        wait_done();
    endtask

    task automatic ack_frame();
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
    endtask

    initial begin
        int s0, a0, t0, d0, acc0;
        bus.i_frame_valid = 1'b0;
        bus.i_code_rate   = 1'b0;
        bus.i_ood         = 1'b0;
        bus.i_ack         = 1'b0;
        bus.i_abort       = 1'b0;

        // Reset, then idle.
        repeat (3) tick();
        check("rst_ready", {31'd0, bus.o_frame_ready}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_ready", {31'd0, bus.o_frame_ready}, 32'd1);
        check("idle_busy",  {31'd0, bus.o_busy}, 32'd0);
        check("idle_outs",  {27'd0, bus.o_en_s, bus.o_en_acs, bus.o_en_tb, bus.o_done, bus.o_err}, 32'd0);
        check("idle_steps", {25'd0, bus.o_steps}, 32'd0);
        check("idle_rate",  {31'd0, bus.o_code_rate}, 32'd0);

        // Rate-2 frame, 69 slice cycles.
        s0 = cnt_s; a0 = cnt_acs; t0 = cnt_tb;
        run_frame(1'b0, 69, 0, 1'b0);
        check("r2_en_s_cycles",   cnt_s - s0, 32'd69);
        check("r2_en_acs_cycles", cnt_acs - a0, 32'd69);
        check("r2_acs_lag",       rise_acs - rise_s, 32'd2);
        check("r2_en_tb_cycles",  cnt_tb - t0, 32'd16);
        check("r2_steps",         {25'd0, bus.o_steps}, 32'd69);
        check("r2_rate",          {31'd0, bus.o_code_rate}, 32'd0);
        check("r2_busy",          {31'd0, bus.o_busy}, 32'd1);
        check("r2_tb_acs_overlap", overlap, 32'd0);
        ack_frame();
        check("r2_ack_done",  {31'd0, bus.o_done}, 32'd0);
        check("r2_ack_ready", {31'd0, bus.o_frame_ready}, 32'd1);

        // Rate-3 frame, 46 slice cycles, input rate flipped mid-frame.
        s0 = cnt_s; t0 = cnt_tb;
        run_frame(1'b1, 46, 20, 1'b0);
        check("r3_en_s_cycles",  cnt_s - s0, 32'd46);
        check("r3_en_tb_cycles", cnt_tb - t0, 32'd16);
        check("r3_steps",        {25'd0, bus.o_steps}, 32'd46);
        check("r3_rate",         {31'd0, bus.o_code_rate}, 32'd1);
        ack_frame();
        bus.i_code_rate = 1'b0;

        // Valid held through the frame, delayed ack.
        acc0 = accepts;
        run_frame(1'b0, 5, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("hold_done",  {31'd0, bus.o_done}, 32'd1);
            check("hold_ready", {31'd0, bus.o_frame_ready}, 32'd0);
            tick();
        end
        ack_frame();
        check("hold_ack_done",  {31'd0, bus.o_done}, 32'd0);
        check("hold_ack_ready", {31'd0, bus.o_frame_ready}, 32'd1);
        check("hold_accepts",   accepts - acc0, 32'd1);
        tick();
        check("next_accept_busy", {31'd0, bus.o_busy}, 32'd1);
        check("next_accept_en_s", {31'd0, bus.o_en_s}, 32'd1);
        bus.i_frame_valid = 1'b0;
        bus.i_ood = 1'b1;
        tick();
        bus.i_ood = 1'b0;
        wait_done();
        check("one_step_steps", {25'd0, bus.o_steps}, 32'd1);
        ack_frame();

        // Abort on the third traceback cycle.
        d0 = cnt_done;
        bus.i_frame_valid = 1'b1;
        tick();
        bus.i_frame_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) bus.i_ood = 1'b1;
            tick();
            bus.i_ood = 1'b0;
        end
        for (int g = 0; g < 50 && bus.o_en_tb !== 1'b1; g++) tick();
        check("abort_tb_started", {31'd0, bus.o_en_tb}, 32'd1);
        repeat (2) tick();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_en_tb", {31'd0, bus.o_en_tb}, 32'd0);
        check("abort_busy",  {31'd0, bus.o_busy}, 32'd0);
        check("abort_ready", {31'd0, bus.o_frame_ready}, 32'd1);
        repeat (30) tick();
        check("abort_no_done", cnt_done - d0, 32'd0);
        check("abort_steps",   {25'd0, bus.o_steps}, 32'd10);

        // Abort coincident with i_ood.
        t0 = cnt_tb; d0 = cnt_done;
        bus.i_frame_valid = 1'b1;
        bus.i_code_rate   = 1'b1;
        tick();
        bus.i_frame_valid = 1'b0;
        repeat (6) tick();
        bus.i_ood   = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        bus.i_ood   = 1'b0;
        bus.i_abort = 1'b0;
        check("abort_ood_busy",   {31'd0, bus.o_busy}, 32'd0);
        check("abort_ood_en_s",   {31'd0, bus.o_en_s}, 32'd0);
        check("abort_ood_en_acs", {31'd0, bus.o_en_acs}, 32'd0);
        check("abort_ood_steps",  {25'd0, bus.o_steps}, 32'd10);
        repeat (30) tick();
        check("abort_ood_no_tb",   cnt_tb - t0, 32'd0);
        check("abort_ood_no_done", cnt_done - d0, 32'd0);

        // Slice with no i_ood.
        t0 = cnt_tb;
        bus.i_frame_valid = 1'b1;
        bus.i_code_rate   = 1'b0;
        tick();
        bus.i_frame_valid = 1'b0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
        repeat (68) tick();
        check("to_cycle69_en_s", {31'd0, bus.o_en_s}, 32'd1);
        check("to_cycle69_err",  {31'd0, bus.o_err}, 32'd0);
        tick();
        check("to_en_s_off", {31'd0, bus.o_en_s}, 32'd0);
        check("to_err",      {31'd0, bus.o_err}, 32'd1);
        check("to_steps",    {25'd0, bus.o_steps}, 32'd69);
        repeat (20) tick();
        check("to_err_held", {31'd0, bus.o_err}, 32'd1);
        check("to_no_tb",    cnt_tb - t0, 32'd0);
        ack_frame();
        check("to_ack_err",  {31'd0, bus.o_err}, 32'd0);
        check("to_ack_busy", {31'd0, bus.o_busy}, 32'd0);
`else
        repeat (199) tick();
        check("noto_en_s_200", {31'd0, bus.o_en_s}, 32'd1);
        check("noto_err",      {31'd0, bus.o_err}, 32'd0);
        check("noto_busy",     {31'd0, bus.o_busy}, 32'd1);
        check("noto_no_tb",    cnt_tb - t0, 32'd0);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("noto_abort_en_s", {31'd0, bus.o_en_s}, 32'd0);
`endif

        // Asynchronous reset in the middle of a frame.
        tick();
        bus.i_frame_valid = 1'b1;
        tick();
        bus.i_frame_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_en_s",  {31'd0, bus.o_en_s}, 32'd0);
        check("arst_busy",  {31'd0, bus.o_busy}, 32'd0);
        check("arst_ready", {31'd0, bus.o_frame_ready}, 32'd0);
        check("arst_steps", {25'd0, bus.o_steps}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("arst_ready_after", {31'd0, bus.o_frame_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
